// File: rtl/ip_recv.sv
// IPv4 header parser feeding the UDP stage; zero latency, active follows rx_enable, no backpressure.
// Optional header checksum verification is enabled by defining IP_HEADER_CHECKSUM_EN.
module ip_recv #(
   parameter int DROP_FRAGMENTS = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_enable,
   input  logic [7:0]  data,
   output logic        active,
   output logic [31:0] to_ip,
   output logic [31:0] remote_ip,
   output logic        broadcast,
   output logic [15:0] total_len,
   output logic        proto_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_OPTIONS,
      S_PAYLOAD,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [15:0] r_byte_no;
   logic [3:0]  r_ihl;
   logic        r_mf;
   logic        r_off_nz;
   logic [31:0] r_to_ip;
   logic [31:0] r_remote_ip;
   logic        r_broadcast;
   logic [15:0] r_total_len;
   logic        r_proto_err;

   logic [15:0] w_hdr_bytes;
   logic [15:0] w_min_len;
   logic [15:0] w_byte_inc;
   logic        w_frag_bad;
   logic        w_len_bad;
   logic        w_last_payload;
   logic        w_ip_bcast;
   logic        w_csum_ok;

   assign w_hdr_bytes    = {10'd0, r_ihl, 2'b00};
   assign w_min_len      = w_hdr_bytes + 16'd8;
   assign w_byte_inc     = (r_byte_no == 16'hFFFF) ? r_byte_no : r_byte_no + 16'd1;
   assign w_frag_bad     = (DROP_FRAGMENTS != 0) && (r_mf || r_off_nz || (data != 8'd0));
   assign w_len_bad      = r_total_len < w_min_len;
   assign w_last_payload = r_byte_no == (r_total_len - 16'd1);
   assign w_ip_bcast     = {r_to_ip[23:0], data} == 32'hFFFFFFFF;

`ifdef IP_HEADER_CHECKSUM_EN
   logic [15:0] r_csum;
   logic [7:0]  r_csum_hi;
   logic [16:0] w_csum_sum;
   logic [15:0] w_csum_fold;

   // Each odd byte completes a 16-bit word; the carry is folded back in immediately.
   assign w_csum_sum  = {1'b0, r_csum} + {1'b0, r_csum_hi, data};
   assign w_csum_fold = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
   assign w_csum_ok   = w_csum_fold == 16'hFFFF;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_csum    <= 16'd0;
         r_csum_hi <= 8'd0;
      end else if (rx_enable) begin
         if (r_state == S_IDLE) begin
            r_csum    <= 16'd0;
            r_csum_hi <= data;
         end else if (!r_byte_no[0]) begin
            r_csum_hi <= data;
         end else begin
            r_csum <= w_csum_fold;
         end
      end
   end
`else
   assign w_csum_ok = 1'b1;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_byte_no   <= 16'd0;
         r_ihl       <= 4'd0;
         r_mf        <= 1'b0;
         r_off_nz    <= 1'b0;
         r_to_ip     <= 32'd0;
         r_remote_ip <= 32'd0;
         r_broadcast <= 1'b0;
         r_total_len <= 16'd0;
         r_proto_err <= 1'b0;
      end else begin
         r_proto_err <= 1'b0;
         if (!rx_enable) begin
            r_state   <= S_IDLE;
            r_byte_no <= 16'd0;
         end else begin
            r_byte_no <= w_byte_inc;
            case (r_state)
               S_IDLE: begin
                  if (data[7:4] == 4'd4 && data[3:0] >= 4'd5) begin
                     r_ihl   <= data[3:0];
                     r_state <= S_HEADER;
                  end else begin
                     r_state     <= S_DONE;
                     r_proto_err <= 1'b1;
                  end
               end
               S_HEADER: begin
                  case (r_byte_no)
                     16'd2: r_total_len[15:8] <= data;
                     16'd3: r_total_len[7:0]  <= data;
                     16'd6: begin
                        r_mf     <= data[5];
                        r_off_nz <= |data[4:0];
                     end
                     16'd7: begin
                        if (w_frag_bad) begin
                           r_state     <= S_DONE;
                           r_proto_err <= 1'b1;
                        end
                     end
                     16'd9: begin
                        if (data != 8'd17) begin
                           r_state     <= S_DONE;
                           r_proto_err <= 1'b1;
                        end
                     end
                     16'd12, 16'd13, 16'd14, 16'd15:
                        r_remote_ip <= {r_remote_ip[23:0], data};
                     16'd16, 16'd17, 16'd18:
                        r_to_ip <= {r_to_ip[23:0], data};
                     16'd19: begin
                        r_to_ip     <= {r_to_ip[23:0], data};
                        r_broadcast <= w_ip_bcast;
                        if (w_len_bad || (r_ihl == 4'd5 && !w_csum_ok)) begin
                           r_state     <= S_DONE;
                           r_proto_err <= 1'b1;
                        end else if (r_ihl == 4'd5) begin
                           r_state <= S_PAYLOAD;
                        end else begin
                           r_state <= S_OPTIONS;
                        end
                     end
                     default: ;
                  endcase
               end
               S_OPTIONS: begin
                  if (r_byte_no == w_hdr_bytes - 16'd1) begin
                     if (!w_csum_ok) begin
                        r_state     <= S_DONE;
                        r_proto_err <= 1'b1;
                     end else begin
                        r_state <= S_PAYLOAD;
                     end
                  end
               end
               S_PAYLOAD: begin
                  if (w_last_payload) r_state <= S_DONE;
               end
               S_DONE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign active    = rx_enable && (r_state == S_PAYLOAD);
   assign to_ip     = r_to_ip;
   assign remote_ip = r_remote_ip;
   assign broadcast = r_broadcast;
   assign total_len = r_total_len;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ip_recv.sv
// Directed bench for ip_recv: hand-built IPv4 headers, counts of active cycles and error pulses.
module tb_ip_recv;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_enable = 1'b0;
   logic [7:0]  data = 8'd0;
   logic        active;
   logic [31:0] to_ip;
   logic [31:0] remote_ip;
   logic        broadcast;
   logic [15:0] total_len;
   logic        proto_err;

   always #5 clock = ~clock;

   ip_recv #(.DROP_FRAGMENTS(1)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .rx_enable (rx_enable),
      .data      (data),
      .active    (active),
      .to_ip     (to_ip),
      .remote_ip (remote_ip),
      .broadcast (broadcast),
      .total_len (total_len),
      .proto_err (proto_err)
   );

   typedef logic [7:0] bq_t[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_act, first_act, last_act, n_err, err_idx;
   logic act_after;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Header with a valid checksum, zeroed options, payload byte i = i[7:0].
   function automatic bq_t make_pkt(input logic [7:0] b0, input int tlen, input logic [7:0] flags,
                                    input logic [7:0] proto, input logic [31:0] src,
                                    input logic [31:0] dst);
      bq_t q;
      int hlen;
      int n;
      int acc;
      logic [15:0] cs;
      hlen = int'(b0[3:0]) * 4;
      n = (tlen > hlen) ? tlen : hlen;
      for (int i = 0; i < n; i++) q.push_back((i >= hlen) ? i[7:0] : 8'h00);
      q[0] = b0;
      q[2] = tlen[15:8];
      q[3] = tlen[7:0];
      q[6] = flags;
      q[8] = 8'h40;
      q[9] = proto;
      for (int i = 0; i < 4; i++) begin
         q[12 + i] = src[31 - 8 * i -: 8];
         q[16 + i] = dst[31 - 8 * i -: 8];
      end
      acc = 0;
      for (int i = 0; i + 1 < hlen; i += 2) begin
         acc = acc + {16'd0, q[i], q[i + 1]};
         if (acc > 32'h0000FFFF) acc = (acc & 32'h0000FFFF) + 1;
      end
      cs = ~acc[15:0];
      q[10] = cs[15:8];
      q[11] = cs[7:0];
      return q;
   endfunction

   task automatic send(input bq_t q, input int cut, input int pad);
      int n;
      n_act = 0; first_act = -1; last_act = -1; n_err = 0; err_idx = -1;
      n = (cut >= 0) ? cut : q.size();
      for (int i = 0; i < n + pad; i++) begin
         rx_enable = 1'b1;
         data = (i < q.size()) ? q[i] : 8'hA5;
         #2;
         if (active) begin
            n_act++;
            if (first_act < 0) first_act = i;
            last_act = i;
         end
         @(posedge clock); #1;
         if (proto_err) begin
            n_err++;
            if (err_idx < 0) err_idx = i;
         end
      end
      rx_enable = 1'b0;
      data = 8'd0;
      #2;
      act_after = active;
      @(posedge clock); #1;
      if (proto_err) n_err++;
      @(posedge clock); #1;
   endtask

   bq_t pa, pb, pc, pd;

   initial begin
      #3;
      check("rst_to_ip", to_ip, 32'd0);
      check("rst_remote_ip", remote_ip, 32'd0);
      check("rst_total_len", {16'd0, total_len}, 32'd0);
      check("rst_broadcast", {31'd0, broadcast}, 32'd0);
      check("rst_proto_err", {31'd0, proto_err}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      #9 reset_n = 1'b1;
      @(posedge clock); #1;

      pa = make_pkt(8'h45, 36, 8'h40, 8'd17, 32'hC0A80101, 32'hC0A8010A);
      send(pa, -1, 6);
      check("a_remote_ip", remote_ip, 32'hC0A80101);
      check("a_to_ip", to_ip, 32'hC0A8010A);
      check("a_broadcast", {31'd0, broadcast}, 32'd0);
      check("a_total_len", {16'd0, total_len}, 32'd36);
      check("a_n_active", n_act, 16);
      check("a_first_active", first_act, 20);
      check("a_last_active", last_act, 35);
      check("a_n_err", n_err, 0);

      pb = make_pkt(8'h45, 28, 8'h00, 8'd17, 32'h0A000001, 32'hFFFFFFFF);
      send(pb, -1, 4);
      check("b_broadcast", {31'd0, broadcast}, 32'd1);
      check("b_n_active", n_act, 8);
      check("b_first_active", first_act, 20);

      pc = make_pkt(8'h46, 40, 8'h00, 8'd17, 32'h0A000002, 32'h0A000003);
      send(pc, -1, 2);
      check("opt_n_active", n_act, 16);
      check("opt_first_active", first_act, 24);
      check("opt_last_active", last_act, 39);
      check("opt_broadcast", {31'd0, broadcast}, 32'd0);

      pd = make_pkt(8'h45, 36, 8'h00, 8'd1, 32'h0A000001, 32'h0A000002);
      send(pd, -1, 0);
      check("icmp_err_idx", err_idx, 9);
      check("icmp_n_err", n_err, 1);
      check("icmp_n_active", n_act, 0);

      pd = make_pkt(8'h65, 36, 8'h00, 8'd17, 32'h0A000001, 32'h0A000002);
      send(pd, -1, 0);
      check("ver6_err_idx", err_idx, 0);
      check("ver6_n_err", n_err, 1);
      check("ver6_n_active", n_act, 0);

      pd = make_pkt(8'h45, 36, 8'h20, 8'd17, 32'h0A000001, 32'h0A000002);
      send(pd, -1, 0);
      check("frag_err_idx", err_idx, 7);
      check("frag_n_active", n_act, 0);

      pd = make_pkt(8'h45, 20, 8'h00, 8'd17, 32'h0A000001, 32'h0A000002);
      send(pd, -1, 0);
      check("short_len_err_idx", err_idx, 19);
      check("short_len_n_active", n_act, 0);

      send(pa, 24, 0);
      check("abort_n_active", n_act, 4);
      check("abort_active_after", {31'd0, act_after}, 32'd0);
      check("abort_n_err", n_err, 0);
      send(pb, -1, 2);
      check("after_abort_remote_ip", remote_ip, 32'h0A000001);
      check("after_abort_broadcast", {31'd0, broadcast}, 32'd1);
      check("after_abort_n_active", n_act, 8);

`ifdef IP_HEADER_CHECKSUM_EN
      pd = pa;
      pd[10] = pd[10] + 8'd1;
      send(pd, -1, 2);
      check("csum_bad_err_idx", err_idx, 19);
      check("csum_bad_n_active", n_act, 0);
`endif

      for (int i = 0; i < 26; i++) begin
         rx_enable = 1'b1;
         data = pa[i];
         @(posedge clock); #1;
      end
      rx_enable = 1'b1;
      data = pa[26];
      #2;
      check("pre_rst_active", {31'd0, active}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_active", {31'd0, active}, 32'd0);
      check("mid_rst_to_ip", to_ip, 32'd0);
      check("mid_rst_remote_ip", remote_ip, 32'd0);
      check("mid_rst_total_len", {16'd0, total_len}, 32'd0);
      rx_enable = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      send(pa, -1, 0);
      check("post_rst_n_active", n_act, 16);
      check("post_rst_to_ip", to_ip, 32'hC0A8010A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ip_recv.md
Name: ip_recv

Overview:
- IPv4 header parser sitting directly upstream of the UDP receive stage.
- Consumes the byte stream that follows the Ethernet header once the MAC stage has matched ethertype 0x0800.
- Validates the IPv4 header, captures source and destination addresses, and skips any options.
- Asserts `active` for exactly the IP payload bytes of UDP datagrams, so the UDP stage sees the first UDP header byte on the first active cycle.

Parameters:
- DROP_FRAGMENTS, 1, when 1 reject any packet with the MF flag set or a nonzero fragment offset.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_enable  input  1  high while IP bytes stream in; first high cycle carries IP byte 0; low = frame over.
- data  input  8  current IP byte; valid when rx_enable is high.
- active  output  1  combinational: rx_enable & (state == PAYLOAD); drives the UDP stage rx_enable.
- to_ip  output  32  destination IP (header bytes 16..19).
- remote_ip  output  32  source IP (header bytes 12..15).
- broadcast  output  1  to_ip == 32'hFFFFFFFF; registered, valid from byte 20 onward.
- total_len  output  16  IP total length field.
- proto_err  output  1  one-cycle pulse when a packet is rejected; debug and counter use.

Behaviour:
- Reset: state = IDLE; to_ip, remote_ip, total_len, byte_no = 0; broadcast, proto_err = 0. `active` is 0 because state is not PAYLOAD.
- rx_enable low in any state: next state = IDLE and byte_no = 0. Captured addresses hold their values, and no proto_err is raised for the abort.
- States: IDLE, HEADER, OPTIONS, PAYLOAD, DONE. byte_no is 16 bits and is the index of the current byte.
- IDLE (rx_enable high, byte 0):
  - upper nibble must be 4 and IHL (data[3:0]) must be >= 5;
  - if both hold: store IHL, byte_no <= 1, go to HEADER;
  - otherwise go to DONE and pulse proto_err.
- HEADER, by index:
  - 2 and 3: total_len high, then low byte.
  - 6: flags; MF = data[5], offset high = data[4:0].
  - 7: offset low. With DROP_FRAGMENTS=1, MF set or any offset bit nonzero -> DONE, proto_err.
  - 9: protocol must be 17; any other value -> DONE, proto_err.
  - 12..15: remote_ip, MSB first. 16..19: to_ip, MSB first.
  - After byte 19: broadcast is set from the to_ip compare.
- Length check at the end of byte 19:
  - if total_len < IHL*4 + 8 -> DONE, proto_err;
  - else if IHL == 5 -> PAYLOAD;
  - else -> OPTIONS.
- OPTIONS: discard bytes until byte_no == IHL*4 - 1, then go to PAYLOAD.
- PAYLOAD: active high. On the byte where byte_no == total_len - 1 (the last payload byte), next state = DONE.
- DONE: ignore all bytes, including Ethernet padding and CRC, until rx_enable falls.
- byte_no saturates at 16'hFFFF; it never wraps while rx_enable is held high.
- Latency: zero. The payload byte and its `active` appear in the same cycle as the input byte.
- Address and length outputs stay stable from their capture until they are overwritten by the next packet.

Optional Feature:
- Macro: IP_HEADER_CHECKSUM_EN.
- When defined:
  - HEADER and OPTIONS accumulate a 16-bit ones-complement sum over the header words (bytes 0..IHL*4-1), with end-around carry.
  - On the final header byte the folded sum must equal 16'hFFFF.
  - If it does not, go to DONE and pulse proto_err instead of entering PAYLOAD.
- When undefined: no accumulator is built and the header checksum is ignored.

Test Plan:
- Valid UDP packet to 192.168.1.10 from 192.168.1.1, IHL=5, total_len=36 -> remote_ip = C0A80101, to_ip = C0A8010A, broadcast = 0; active high for exactly 16 cycles (bytes 20..35); pad bytes after that give active = 0.
- Destination 255.255.255.255, UDP, total_len=28 -> broadcast = 1; active for 8 cycles.
- IHL=6, total_len=40 -> bytes 20..23 skipped; active for bytes 24..39 (16 cycles).
- Protocol 1 (ICMP) -> proto_err pulses at byte 9; active never asserts. Version 6 -> proto_err at byte 0.
- Fragment with MF=1 and DROP_FRAGMENTS=1 -> proto_err at byte 7. rx_enable dropped at payload byte 3, then a new packet -> active falls immediately and the new packet parses correctly. reset_n pulsed low mid-payload -> all outputs return to 0 asynchronously.
- With IP_HEADER_CHECKSUM_EN defined: correct checksum -> PAYLOAD reached; checksum byte corrupted by 1 -> proto_err after byte 19, active = 0.
